// File: rtl/core_if_inst_queue.sv
// Fetch-side instruction queue between IF and decode.
// Circular buffer with flush and optional empty-queue bypass.
module core_if_inst_queue #(
  parameter int DEPTH  = 4,
  parameter int INST_W = 32,
  parameter int PC_W   = 32,
  parameter int BYPASS = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  output logic                       ready_in,
  input  logic [INST_W-1:0]          i_inst,
  input  logic [PC_W-1:0]            i_pc,
  input  logic                       i_branch_predict,
  output logic                       valid_out,
  input  logic                       ready_out,
  output logic [INST_W-1:0]          o_inst,
  output logic [PC_W-1:0]            o_pc,
  output logic                       o_branch_predict,
  input  logic                       i_pipe_flush_req,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic              bp_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic empty;
  logic full;
  logic byp_path;
  logic push;
  logic pop;
  logic byp_take;
  logic wr_en;
  logic rd_en;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign byp_path = (BYPASS != 0) && empty;

  assign ready_in = ~full & ~i_pipe_flush_req;

  // Head selection: empty bypass forwards the live input.
  always_comb begin
    valid_out        = ~empty & ~i_pipe_flush_req;
    o_inst           = inst_mem[rd_ptr];
    o_pc             = pc_mem[rd_ptr];
    o_branch_predict = bp_mem[rd_ptr];
    if (byp_path) begin
      valid_out        = valid_in & ~i_pipe_flush_req;
      o_inst           = i_inst;
      o_pc             = i_pc;
      o_branch_predict = i_branch_predict;
    end
  end

  assign push     = valid_in & ready_in;
  assign pop      = valid_out & ready_out;
  // A bypassed entry is consumed in flight and never stored.
  assign byp_take = byp_path & pop;
  assign wr_en    = push & ~byp_take;
  assign rd_en    = pop & ~byp_take;

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      inst_mem[wr_ptr] <= i_inst;
      pc_mem[wr_ptr]   <= i_pc;
      bp_mem[wr_ptr]   <= i_branch_predict;
    end
  end

  // Pointers and occupancy; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (!rst_n || i_pipe_flush_req) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en && !rd_en)
        count <= count + CNT_W'(1);
      else if (!wr_en && rd_en)
        count <= count - CNT_W'(1);
    end
  end

  assign o_count = count;

endmodule

// File: tb/tb_core_if_inst_queue.sv
// Randomized bench for core_if_inst_queue.
// Runs BYPASS=0 and BYPASS=1 side by side against queue models.
module tb_core_if_inst_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        bp;
  } ent_t;

  logic clk;
  logic rst_n;
  logic valid_in;
  logic [31:0] inst_i;
  logic [31:0] pc_i;
  logic bp_i;
  logic ready_out;
  logic flush;

  logic [1:0]       ri;
  logic [1:0]       vo;
  logic [1:0][31:0] inst_o;
  logic [1:0][31:0] pc_o;
  logic [1:0]       bp_o;
  logic [1:0][2:0]  cnt_o;

  ent_t q [2][$];

  int n_chk;
  int n_fail;

  core_if_inst_queue #(
    .DEPTH(DEPTH), .INST_W(32), .PC_W(32), .BYPASS(0)
  ) u_q0 (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .ready_in(ri[0]),
    .i_inst(inst_i), .i_pc(pc_i),
    .i_branch_predict(bp_i),
    .valid_out(vo[0]), .ready_out(ready_out),
    .o_inst(inst_o[0]), .o_pc(pc_o[0]),
    .o_branch_predict(bp_o[0]),
    .i_pipe_flush_req(flush),
    .o_count(cnt_o[0])
  );

  core_if_inst_queue #(
    .DEPTH(DEPTH), .INST_W(32), .PC_W(32), .BYPASS(1)
  ) u_q1 (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .ready_in(ri[1]),
    .i_inst(inst_i), .i_pc(pc_i),
    .i_branch_predict(bp_i),
    .valid_out(vo[1]), .ready_out(ready_out),
    .o_inst(inst_o[1]), .o_pc(pc_o[1]),
    .o_branch_predict(bp_o[1]),
    .i_pipe_flush_req(flush),
    .o_count(cnt_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag,
                       logic [63:0] got,
                       logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic drv(bit v, logic [31:0] pc,
                     bit ro, bit fl);
    valid_in  = v;
    pc_i      = pc;
    inst_i    = $urandom;
    bp_i      = 1'($urandom);
    ready_out = ro;
    flush     = fl;
  endtask

  // Check outputs mid-cycle, then advance the models over the edge.
  task automatic step();
    ent_t e;
    ent_t h;
    int   n;
    bit   byp;
    bit   push;
    bit   pop;
    bit   ev;
    @(negedge clk);
    e.inst = inst_i;
    e.pc   = pc_i;
    e.bp   = bp_i;
    for (int k = 0; k < 2; k++) begin
      byp = (k == 1);
      n   = q[k].size();
      ev  = !flush && (n > 0 || (byp && valid_in));
      if (rst_n) begin
        check($sformatf("b%0d_ready_in", k),
              64'(ri[k]),
              64'(n < DEPTH && !flush));
        check($sformatf("b%0d_valid_out", k),
              64'(vo[k]), 64'(ev));
        check($sformatf("b%0d_count", k),
              64'(cnt_o[k]), 64'(n));
        if (ev) begin
          h = (n > 0) ? q[k][0] : e;
          check($sformatf("b%0d_pc", k),
                64'(pc_o[k]), 64'(h.pc));
          check($sformatf("b%0d_inst", k),
                64'(inst_o[k]), 64'(h.inst));
          check($sformatf("b%0d_bp", k),
                64'(bp_o[k]), 64'(h.bp));
        end
      end
      if (!rst_n || flush) begin
        q[k].delete();
      end else begin
        push = valid_in && (n < DEPTH);
        pop  = ev && ready_out;
        if (pop && n > 0) void'(q[k].pop_front());
        if (push && !(pop && n == 0))
          q[k].push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bias;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drv(0, 0, 0, 0);
    step();
    step();
    rst_n = 1'b1;
    // Reset state
    step();

    // Fill to full, try a fifth, then drain
    for (int i = 0; i < 4; i++) begin
      drv(1, 32'(i*4), 0, 0);
      step();
    end
    drv(1, 32'h10, 0, 0);
    step();
    check("full_count", 64'(cnt_o[0]), 64'd4);
    check("full_ready", 64'(ri[0]), 64'd0);
    for (int i = 0; i < 6; i++) begin
      drv(0, 0, 1, 0);
      step();
    end

    // Steady streaming
    for (int i = 0; i < 20; i++) begin
      drv(1, 32'h100 + 32'(i*4), 1, 0);
      step();
    end
    drv(0, 0, 1, 0);
    step();

    // Flush with three entries and a live input
    for (int i = 0; i < 3; i++) begin
      drv(1, 32'h200 + 32'(i*4), 0, 0);
      step();
    end
    drv(1, 32'hdead, 1, 1);
    step();
    drv(1, 32'hbeef, 1, 1);
    step();
    check("flush_count", 64'(cnt_o[0]), 64'd0);
    drv(1, 32'h300, 0, 0);
    step();
    drv(0, 0, 1, 0);
    step();
    step();

    // Full plus pop with a valid input
    for (int i = 0; i < 4; i++) begin
      drv(1, 32'h400 + 32'(i*4), 0, 0);
      step();
    end
    drv(1, 32'h4f0, 1, 0);
    step();
    check("fullpop_count", 64'(cnt_o[0]), 64'd3);
    drv(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step();

    // Bypass on empty queue
    drv(1, 32'h80, 1, 0);
    step();
    check("byp_count", 64'(cnt_o[1]), 64'd0);
    drv(1, 32'h84, 0, 0);
    step();
    check("byp_store", 64'(cnt_o[1]), 64'd1);
    drv(0, 0, 1, 0);
    step();
    step();

    // Reset mid-stream
    for (int i = 0; i < 2; i++) begin
      drv(1, 32'h500 + 32'(i*4), 0, 0);
      step();
    end
    rst_n = 1'b0;
    drv(1, 32'h5f0, 1, 0);
    step();
    rst_n = 1'b1;
    drv(1, 32'h600, 0, 0);
    step();
    drv(0, 0, 1, 0);
    step();
    step();

    // Random traffic with varying backpressure
    bias = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) bias = $urandom_range(0, 4);
      rst_n = ($urandom_range(0, 299) != 0);
      drv($urandom_range(0, 3) != 0,
          $urandom,
          $urandom_range(0, 3) < bias,
          $urandom_range(0, 39) == 0);
      step();
    end
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
